gpac_adc_avg: RTL and testbench

Block-averaging stage between the `gpac_adc_rx` FIFO read interface and `bram_fifo`. It pulls raw ADC words with first-word-fall-through (FWFT) semantics and sums 2^LOG2_N consecutive 14-bit samples. It presents each completed sum as one 32-bit word on an identical FWFT interface. A bypass mode forwards raw words unchanged, and backpressure from downstream stalls upstream reads, so no word is ever dropped.

---
 rtl/gpac_adc_avg.sv | 64 ++++++
 tb/tb_gpac_adc_avg.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/gpac_adc_avg.sv
// gpac_adc_avg: FWFT block averager summing 2^LOG2_N ADC samples per output word, with raw bypass
module gpac_adc_avg #(
  parameter int         LOG2_N     = 4,
  parameter logic [3:0] OUT_HEADER = 4'h5
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST,
  input  logic        ENABLE,
  input  logic        CLEAR,
  output logic        FIFO_READ,
  input  logic        FIFO_EMPTY,
  input  logic [31:0] FIFO_DATA,
  input  logic        FIFO_READ_OUT,
  output logic        FIFO_EMPTY_OUT,
  output logic [31:0] FIFO_DATA_OUT,
  output logic        BUSY
);
  typedef enum logic {BYPASS, ACCUM} state_t;
  state_t                 state_q;
  logic [LOG2_N-1:0]      cnt_q;
  logic [13+LOG2_N:0]     acc_q, acc_d;
  logic                   valid_q;
  logic [31:0]            data_q, data_d;
  logic                   free, last, mode_ok, load;
  // Pop/load decisions; a pending mode change or CLEAR suppresses the upstream pop
  always_comb begin
    free      = !valid_q | FIFO_READ_OUT;
    last      = (state_q == ACCUM) && (cnt_q == '1);
    mode_ok   = (state_q == ACCUM) == ENABLE;
    FIFO_READ = !BUS_RST && !CLEAR && !FIFO_EMPTY && mode_ok && (((state_q == ACCUM) && !last) || free);
    load      = FIFO_READ && ((state_q == BYPASS) || last);
    acc_d     = acc_q + {{LOG2_N{1'b0}}, FIFO_DATA[13:0]};
    data_d    = (state_q == BYPASS) ? FIFO_DATA : {OUT_HEADER, 28'(acc_d)};
  end
  // Mode FSM, block accumulator and the single-word output register
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (!mode_ok) begin
        state_q <= ENABLE ? ACCUM : BYPASS;
        cnt_q   <= '0;
        acc_q   <= '0;
      end else if (CLEAR || load) begin
        cnt_q <= '0;
        acc_q <= '0;
      end else if (FIFO_READ) begin
        cnt_q <= cnt_q + LOG2_N'(1);
        acc_q <= acc_d;
      end
      if (load) begin
        valid_q <= 1'b1;
        data_q  <= data_d;
      end else if (FIFO_READ_OUT) valid_q <= 1'b0;
    end
  end
  assign FIFO_EMPTY_OUT = !valid_q;
  assign FIFO_DATA_OUT  = data_q;
  assign BUSY           = cnt_q != '0;
endmodule

// File: tb/tb_gpac_adc_avg.sv
// tb_gpac_adc_avg: two averager instances (4 and 16 samples/block) against a queue-based model
module tb_gpac_adc_avg;
  logic        clk = 1'b0, rst = 1'b1, enable = 1'b1, clear = 1'b0, rd_out = 1'b0;
  logic        rd[2], emp[2], emp_out[2], busy[2];
  logic [31:0] din[2], dout[2];
  logic [31:0] mem[1024];
  int          wp = 0;
  int          rp[2];
  int          tests = 0, fails = 0;
  int          blk[2][$];
  logic [31:0] got[2][$];
  logic        macc[2], mv[2];
  logic [31:0] mw[2];
  int          lowc[2], busyc[2];

  always #5 clk = ~clk;

  always_comb
    for (int d = 0; d < 2; d++) begin
      emp[d] = rp[d] == wp;
      din[d] = mem[rp[d]];
    end

  gpac_adc_avg #(.LOG2_N(2)) u_n4 (
    .BUS_CLK(clk), .BUS_RST(rst), .ENABLE(enable), .CLEAR(clear),
    .FIFO_READ(rd[0]), .FIFO_EMPTY(emp[0]), .FIFO_DATA(din[0]),
    .FIFO_READ_OUT(rd_out), .FIFO_EMPTY_OUT(emp_out[0]), .FIFO_DATA_OUT(dout[0]), .BUSY(busy[0]));
  gpac_adc_avg #(.LOG2_N(4)) u_n16 (
    .BUS_CLK(clk), .BUS_RST(rst), .ENABLE(enable), .CLEAR(clear),
    .FIFO_READ(rd[1]), .FIFO_EMPTY(emp[1]), .FIFO_DATA(din[1]),
    .FIFO_READ_OUT(rd_out), .FIFO_EMPTY_OUT(emp_out[1]), .FIFO_DATA_OUT(dout[1]), .BUSY(busy[1]));

  task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp_v, $time);
    end
  endtask

  task automatic push(logic [31:0] w);
    mem[wp] = w;
    wp++;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      macc[d] = 1'b1;
      mv[d]   = 1'b0;
      mw[d]   = '0;
      blk[d].delete();
      rp[d]   = wp;
    end
  endtask

  task automatic tick();
    logic er[2];
    logic lst[2];
    logic [31:0] w;
    int s, n;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n      = (d == 0) ? 4 : 16;
      lst[d] = blk[d].size() == n - 1;
      er[d]  = !clear && !emp[d] && (macc[d] == enable) && ((macc[d] && !lst[d]) || !mv[d] || rd_out);
      chk("fifo_read", d, 32'(rd[d]), 32'(er[d]));
      chk("busy", d, 32'(busy[d]), 32'(blk[d].size() != 0));
      chk("empty_out", d, 32'(emp_out[d]), 32'(!mv[d]));
      if (mv[d]) chk("data_out", d, dout[d], mw[d]);
      if (rd_out && !emp_out[d]) got[d].push_back(dout[d]);
      if (!emp_out[d]) lowc[d]++;
      if (busy[d]) busyc[d]++;
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (macc[d] != enable) begin
        macc[d] = enable;
        blk[d].delete();
      end else if (clear) blk[d].delete();
      if (er[d] && (!macc[d] || lst[d])) begin
        if (macc[d]) begin
          s = int'(din[d][13:0]);
          for (int i = 0; i < blk[d].size(); i++) s += blk[d][i];
          w = {4'h5, 28'(s)};
          blk[d].delete();
        end else w = din[d];
        mv[d] = 1'b1;
        mw[d] = w;
      end else begin
        if (er[d]) blk[d].push_back(int'(din[d][13:0]));
        if (rd_out) mv[d] = 1'b0;
      end
      if (er[d]) rp[d]++;
    end
  endtask

  task automatic ticks(int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic restart_counts();
    for (int d = 0; d < 2; d++) begin
      got[d].delete();
      lowc[d]  = 0;
      busyc[d] = 0;
    end
  endtask

  initial begin
    model_reset();
    #2;
    chk("reset empty_out", 0, 32'(emp_out[0]), 32'd1);
    chk("reset data_out", 0, dout[0], 32'h0);
    chk("reset busy", 0, 32'(busy[0]), 32'd0);
    chk("reset fifo_read", 0, 32'(rd[0]), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    rd_out = 1'b1;
    restart_counts();
    push(1); push(2); push(3); push(4);
    ticks(8);
    chk("sum1234 count", 0, got[0].size(), 1);
    chk("sum1234 word", 0, got[0][0], 32'h5000000A);
    chk("sum1234 valid cycles", 0, lowc[0], 1);
    chk("sum1234 busy cycles", 0, busyc[0], 3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    restart_counts();
    for (int i = 0; i < 16; i++) push(32'hFFFFFFFF);
    ticks(20);
    chk("max16 word", 1, got[1][0], 32'h5003FFF0);
    chk("max4 count", 0, got[0].size(), 4);
    chk("max4 word", 0, got[0][0], 32'h5000FFFC);
    rd_out = 1'b0;
    restart_counts();
    for (int i = 0; i < 8; i++) push(1);
    ticks(10);
    #1;
    chk("bp pending", 0, wp - rp[0], 1);
    chk("bp read stalled", 0, 32'(rd[0]), 32'd0);
    chk("bp held word", 0, dout[0], 32'h50000004);
    chk("bp busy", 0, 32'(busy[0]), 32'd1);
    rd_out = 1'b1;
    ticks(4);
    chk("bp count", 0, got[0].size(), 2);
    chk("bp first", 0, got[0][0], 32'h50000004);
    chk("bp second", 0, got[0][1], 32'h50000004);
    restart_counts();
    push(7); push(7);
    ticks(3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    push(1); push(1); push(1); push(1);
    ticks(6);
    chk("clear count", 0, got[0].size(), 1);
    chk("clear word", 0, got[0][0], 32'h50000004);
    restart_counts();
    enable = 1'b0;
    tick();
    push(32'hDEADBEEF); push(32'h00000001);
    ticks(4);
    chk("bypass count", 0, got[0].size(), 2);
    chk("bypass w0", 0, got[0][0], 32'hDEADBEEF);
    chk("bypass w1", 0, got[0][1], 32'h00000001);
    chk("bypass w0", 1, got[1][0], 32'hDEADBEEF);
    restart_counts();
    enable = 1'b1;
    tick();
    push(9); push(9);
    ticks(3);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    push(1); push(1); push(1); push(1);
    ticks(6);
    chk("toggle count", 0, got[0].size(), 1);
    chk("toggle word", 0, got[0][0], 32'h50000004);
    rd_out = 1'b0;
    push(1); push(1); push(1); push(1);
    ticks(6);
    push(2); push(2);
    ticks(3);
    #1;
    chk("pre-reset busy", 0, 32'(busy[0]), 32'd1);
    chk("pre-reset empty_out", 0, 32'(emp_out[0]), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("async empty_out", 0, 32'(emp_out[0]), 32'd1);
    chk("async data_out", 0, dout[0], 32'h0);
    chk("async busy", 0, 32'(busy[0]), 32'd0);
    rst = 1'b0;
    model_reset();
    restart_counts();
    rd_out = 1'b1;
    push(3); push(3); push(3); push(3);
    ticks(8);
    chk("post-reset count", 0, got[0].size(), 1);
    chk("post-reset word", 0, got[0][0], 32'h5000000C);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
